// File: rtl/seq_hit_monitor_pkg.sv
// Shared types and defaults for the windowed
// hit monitor that follows the 1011 detector.
package seq_hit_monitor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;

endpackage

// File: rtl/seq_hit_report_reg.sv
// Report holding register: valid/ready output,
// one-cycle alarm pulse and sticky overrun flag.
module seq_hit_report_reg
  import seq_hit_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] data,
  input  logic             alarm_set,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  output logic             alarm,
  output logic             overrun
);

  logic ovr_set;

  // Overwriting a report nobody took is an overrun.
  assign ovr_set = load & cnt_valid & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
      alarm     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      alarm <= load & alarm_set;
      if (load) begin
        cnt_data  <= data;
        cnt_valid <= 1'b1;
      end else if (cnt_valid && ready) begin
        cnt_valid <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_hit_monitor.sv
// Counts detector hits over back-to-back windows
// and reports each completed window count.
module seq_hit_monitor
  import seq_hit_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             ovr_clr,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             alarm,
  output logic             overrun
);

  state_t state_q, state_d;

  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] cnt_next;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] len_in;
  logic             last;
  logic             start;
  logic             load;
  logic             alarm_set;

  // A zero length would never end; run it as 1.
  assign len_in = (win_len == '0) ? WIN_W'(1) : win_len;
  assign last   = (win_cnt == len_q - WIN_W'(1));

  assign cnt_next = (hit && hit_cnt != '1) ?
                    hit_cnt + CNT_W'(1) : hit_cnt;

  assign alarm_set = (thr_q != '0) &&
                     (cnt_next >= thr_q);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COUNT;
          start   = 1'b1;
        end
      end
      COUNT: begin
        if (last) begin
          load    = 1'b1;
          start   = 1'b1;
          state_d = enable ? COUNT : IDLE;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
      win_cnt <= '0;
      len_q   <= WIN_W'(1);
      thr_q   <= '0;
    end else if (start) begin
      hit_cnt <= '0;
      win_cnt <= '0;
      len_q   <= len_in;
      thr_q   <= thresh;
    end else if (state_q == COUNT) begin
      hit_cnt <= cnt_next;
      win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  seq_hit_report_reg #(
    .CNT_W(CNT_W)
  ) u_report (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (cnt_next),
    .alarm_set(alarm_set),
    .ready    (cnt_ready),
    .ovr_clr  (ovr_clr),
    .cnt_data (cnt_data),
    .cnt_valid(cnt_valid),
    .alarm    (alarm),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Self-checking bench: directed scenarios plus
// random traffic against a window-level model.
module tb_seq_hit_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        hit;
  logic        enable;
  logic [15:0] win_len;
  logic [7:0]  thresh;
  logic        ovr_clr;
  logic        cnt_ready;

  logic [7:0]  cnt_data;
  logic        cnt_valid, alarm, overrun;
  logic [1:0]  cnt_data2;
  logic        cnt_valid2, alarm2, overrun2;

  int checks = 0;
  int errors = 0;

  // model state, index 0: CNT_W=8, index 1: CNT_W=2
  bit m_act[2];
  int m_pos[2], m_len[2], m_thr[2], m_hits[2];
  bit m_valid[2], m_alarm[2], m_ovr[2];
  int m_data[2];

  always #5 clk = ~clk;

  seq_hit_monitor dut (
    .clk(clk), .rst(rst), .hit(hit),
    .enable(enable), .win_len(win_len),
    .thresh(thresh), .ovr_clr(ovr_clr),
    .cnt_data(cnt_data), .cnt_valid(cnt_valid),
    .cnt_ready(cnt_ready), .alarm(alarm),
    .overrun(overrun)
  );

  seq_hit_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .hit(hit),
    .enable(enable), .win_len(win_len),
    .thresh(thresh[1:0]), .ovr_clr(ovr_clr),
    .cnt_data(cnt_data2), .cnt_valid(cnt_valid2),
    .cnt_ready(cnt_ready), .alarm(alarm2),
    .overrun(overrun2)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_pos[k] = 0; m_len[k] = 1;
      m_thr[k] = 0; m_hits[k] = 0;
      m_valid[k] = 0; m_alarm[k] = 0;
      m_ovr[k] = 0; m_data[k] = 0;
    end
  endtask

  task automatic model_update();
    bit rep;
    int cnt, mx;
    bit al;
    for (int k = 0; k < 2; k++) begin
      rep = 0; cnt = 0; al = 0;
      mx = (k == 0) ? 255 : 3;
      if (!m_act[k]) begin
        if (enable) begin
          m_act[k] = 1; m_pos[k] = 0; m_hits[k] = 0;
          m_len[k] = (win_len == 0) ? 1 : int'(win_len);
          m_thr[k] = int'(thresh) % (mx + 1);
        end
      end else begin
        m_hits[k] += int'(hit);
        m_pos[k]++;
        if (m_pos[k] == m_len[k]) begin
          rep = 1;
          cnt = (m_hits[k] > mx) ? mx : m_hits[k];
          al = (m_thr[k] != 0) && (cnt >= m_thr[k]);
          m_pos[k] = 0; m_hits[k] = 0;
          m_len[k] = (win_len == 0) ? 1 : int'(win_len);
          m_thr[k] = int'(thresh) % (mx + 1);
          m_act[k] = enable;
        end else if (!enable) begin
          m_act[k] = 0;
        end
      end
      if (rep && m_valid[k] && !cnt_ready)
        m_ovr[k] = 1;
      else if (ovr_clr)
        m_ovr[k] = 0;
      if (rep) begin
        m_valid[k] = 1; m_data[k] = cnt;
      end else if (m_valid[k] && cnt_ready) begin
        m_valid[k] = 0;
      end
      m_alarm[k] = al;
    end
  endtask

  function automatic logic [10:0] exp0();
    return {8'(m_data[0]), m_valid[0],
            m_alarm[0], m_ovr[0]};
  endfunction

  function automatic logic [4:0] exp1();
    return {2'(m_data[1]), m_valid[1],
            m_alarm[1], m_ovr[1]};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; hit = 0; enable = 0; win_len = 0;
    thresh = 0; ovr_clr = 0; cnt_ready = 0;
    model_reset();
    #12;
    checks++;
    if ({cnt_data, cnt_valid, alarm, overrun} !== 11'd0
        || {cnt_data2, cnt_valid2, alarm2, overrun2}
           !== 5'd0) begin
      errors++;
      $display("FAIL reset: got %h/%h want 0",
        {cnt_data, cnt_valid, alarm, overrun},
        {cnt_data2, cnt_valid2, alarm2, overrun2});
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    int nv = 0, na = 0;
    logic [7:0] got = 0;
    win_len = 10; thresh = 3; cnt_ready = 1;
    enable = 1; hit = 0;
    step();
    for (int c = 1; c <= 12; c++) begin
      hit = (c == 2 || c == 5 || c == 9);
      enable = (c < 10);
      step();
      checks++;
      if ({cnt_data, cnt_valid, alarm, overrun}
          !== exp0()) begin
        errors++;
        $display("FAIL basic c%0d: got %h want %h", c,
          {cnt_data, cnt_valid, alarm, overrun}, exp0());
      end
      nv += int'(cnt_valid);
      na += int'(alarm);
      if (cnt_valid) got = cnt_data;
    end
    checks++;
    if (got !== 8'd3 || nv != 1 || na != 1) begin
      errors++;
      $display("FAIL basic_vec: data %0d valid %0d alarm %0d want 3 1 1",
        got, nv, na);
    end
  endtask

  task automatic test_saturation();
    int nrep = 0, lastc = 0;
    win_len = 4; thresh = 0; cnt_ready = 1;
    enable = 1; hit = 1;
    step();
    for (int c = 1; c <= 14; c++) begin
      enable = (c < 12);
      step();
      checks++;
      if ({cnt_data2, cnt_valid2, alarm2, overrun2}
          !== exp1() ||
          {cnt_data, cnt_valid, alarm, overrun}
          !== exp0()) begin
        errors++;
        $display("FAIL sat c%0d: got %h/%h want %h/%h", c,
          {cnt_data, cnt_valid, alarm, overrun},
          {cnt_data2, cnt_valid2, alarm2, overrun2},
          exp0(), exp1());
      end
      if (cnt_valid2) begin
        nrep++;
        checks++;
        if (cnt_data2 !== 2'd3 ||
            (lastc != 0 && c - lastc != 4)) begin
          errors++;
          $display("FAIL sat_rep c%0d: data %0d gap %0d want 3 4",
            c, cnt_data2, c - lastc);
        end
        lastc = c;
      end
    end
    checks++;
    if (nrep != 3) begin
      errors++;
      $display("FAIL sat_count: got %0d want 3", nrep);
    end
    hit = 0;
  endtask

  task automatic test_overrun();
    win_len = 5; thresh = 0; cnt_ready = 0;
    enable = 1;
    step();
    for (int c = 1; c <= 10; c++) begin
      hit = 1'($urandom_range(0, 1));
      enable = (c < 10);
      step();
      checks++;
      if ({cnt_data, cnt_valid, alarm, overrun}
          !== exp0()) begin
        errors++;
        $display("FAIL ovr c%0d: got %h want %h", c,
          {cnt_data, cnt_valid, alarm, overrun}, exp0());
      end
    end
    checks++;
    if (overrun !== 1'b1 || cnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: ovr %b valid %b want 1 1",
        overrun, cnt_valid);
    end
    hit = 0; ovr_clr = 1;
    step();
    ovr_clr = 0;
    checks++;
    if (overrun !== 1'b0 || cnt_valid !== 1'b1 ||
        {cnt_data, cnt_valid, alarm, overrun}
        !== exp0()) begin
      errors++;
      $display("FAIL ovr_clr: got %h want %h (ovr 0)",
        {cnt_data, cnt_valid, alarm, overrun}, exp0());
    end
    cnt_ready = 1;
    step();
    checks++;
    if (cnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drain: valid %b want 0", cnt_valid);
    end
  endtask

  task automatic test_abort();
    logic [7:0] got = 8'hff;
    win_len = 8; thresh = 1; cnt_ready = 1;
    enable = 1; hit = 1;
    step();
    for (int c = 1; c <= 6; c++) begin
      enable = (c < 3);
      step();
      checks++;
      if (cnt_valid !== 1'b0 || alarm !== 1'b0 ||
          {cnt_data, cnt_valid, alarm, overrun}
          !== exp0()) begin
        errors++;
        $display("FAIL abort c%0d: got %h want %h (no report)",
          c, {cnt_data, cnt_valid, alarm, overrun}, exp0());
      end
    end
    enable = 1; hit = 0;
    step();
    for (int c = 1; c <= 9; c++) begin
      hit = (c == 8);
      enable = (c < 8);
      step();
      checks++;
      if ({cnt_data, cnt_valid, alarm, overrun}
          !== exp0()) begin
        errors++;
        $display("FAIL restart c%0d: got %h want %h", c,
          {cnt_data, cnt_valid, alarm, overrun}, exp0());
      end
      if (cnt_valid) got = cnt_data;
    end
    checks++;
    if (got !== 8'd1) begin
      errors++;
      $display("FAIL restart_cnt: got %0d want 1", got);
    end
    hit = 0;
  endtask

  task automatic test_reset_mid();
    int nrep = 0;
    win_len = 2; thresh = 1; cnt_ready = 0;
    enable = 1; hit = 1;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (cnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: valid %b want 1", cnt_valid);
    end
    @(negedge clk);
    rst = 1;
    model_reset();
    #1;
    checks++;
    if ({cnt_data, cnt_valid, alarm, overrun} !== 11'd0
        || {cnt_data2, cnt_valid2, alarm2, overrun2}
           !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid: got %h/%h want 0",
        {cnt_data, cnt_valid, alarm, overrun},
        {cnt_data2, cnt_valid2, alarm2, overrun2});
    end
    enable = 0; hit = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    win_len = 0; thresh = 0; cnt_ready = 1;
    enable = 1;
    step();
    for (int c = 1; c <= 7; c++) begin
      hit = 1'($urandom_range(0, 1));
      step();
      checks++;
      if ({cnt_data, cnt_valid, alarm, overrun}
          !== exp0()) begin
        errors++;
        $display("FAIL len0 c%0d: got %h want %h", c,
          {cnt_data, cnt_valid, alarm, overrun}, exp0());
      end
      nrep += int'(cnt_valid);
    end
    checks++;
    if (nrep != 7) begin
      errors++;
      $display("FAIL len0_count: got %0d want 7", nrep);
    end
    enable = 0; hit = 0;
    step();
    step();
  endtask

  task automatic test_detector();
    logic [9:0] stream = 10'b1011011011;
    logic [3:0] sh = 4'd0;
    logic [7:0] got = 8'hff;
    logic b;
    win_len = 12; thresh = 3; cnt_ready = 1;
    enable = 1; hit = 0;
    step();
    for (int c = 1; c <= 13; c++) begin
      b = (c <= 10) ? stream[10 - c] : 1'b0;
      sh = {sh[2:0], b};
      hit = (sh == 4'b1011);
      enable = (c < 12);
      step();
      checks++;
      if ({cnt_data, cnt_valid, alarm, overrun}
          !== exp0()) begin
        errors++;
        $display("FAIL det c%0d: got %h want %h", c,
          {cnt_data, cnt_valid, alarm, overrun}, exp0());
      end
      if (cnt_valid) got = cnt_data;
    end
    checks++;
    if (got !== 8'd3) begin
      errors++;
      $display("FAIL det_cnt: got %0d want 3", got);
    end
    hit = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 7) != 0);
      win_len   = 16'($urandom_range(0, 6));
      thresh    = 8'($urandom_range(0, 4));
      hit       = 1'($urandom_range(0, 1));
      cnt_ready = ($urandom_range(0, 2) != 0);
      ovr_clr   = ($urandom_range(0, 9) == 0);
      step();
      checks++;
      if ({cnt_data, cnt_valid, alarm, overrun}
          !== exp0() ||
          {cnt_data2, cnt_valid2, alarm2, overrun2}
          !== exp1()) begin
        errors++;
        $display("FAIL rand c%0d: got %h/%h want %h/%h", c,
          {cnt_data, cnt_valid, alarm, overrun},
          {cnt_data2, cnt_valid2, alarm2, overrun2},
          exp0(), exp1());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_detector();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_hit_monitor.md
SEQ_HIT_MONITOR -- requirements
Module: seq_hit_monitor

Interface
REQ-001 SHALL have parameter CNT_W, 8, hit-count width.
REQ-002 SHALL have parameter WIN_W, 16, window-length width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port hit  input  1  detection flag from the upstream 1011 sequence detector, sampled every cycle.
REQ-006 SHALL have port enable  input  1  run/stop control for windowed counting.
REQ-007 SHALL have port win_len  input  WIN_W  window length in cycles, latched at each window start.
REQ-008 SHALL have port thresh  input  CNT_W  alarm threshold, latched at each window start.
REQ-009 SHALL have port ovr_clr  input  1  clears the sticky overrun flag.
REQ-010 SHALL have port cnt_data  output  CNT_W  hit count of the last completed window.
REQ-011 SHALL have port cnt_valid  output  1  cnt_data holds an unconsumed report.
REQ-012 SHALL have port cnt_ready  input  1  the consumer accepts the report.
REQ-013 SHALL have port alarm  output  1  one-cycle pulse: the completed window count is >= thresh.
REQ-014 SHALL have port overrun  output  1  sticky flag: an unconsumed report was overwritten.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and COUNT.
REQ-016 In IDLE with enable=1, SHALL enter COUNT next cycle, latch win_len (0 treated as 1) and thresh, and clear hit_cnt and win_cnt.
REQ-017 In COUNT, SHALL add hit to hit_cnt each cycle, saturating at 2^CNT_W-1, and increment win_cnt.
REQ-018 A window SHALL span exactly L COUNT cycles (L = latched length); the hit on the last cycle is included in the report.
REQ-019 On the last window cycle, SHALL load the final count into cnt_data and set cnt_valid the next cycle (latency 1).
REQ-020 On the same last window cycle, SHALL clear hit_cnt and win_cnt, re-latch win_len and thresh, and stay in COUNT if enable=1, else go to IDLE; windows are back-to-back with no gap cycle.
REQ-021 enable=0 before the last window cycle SHALL abort the window: go to IDLE next cycle, discard the partial count, no report, no alarm.
REQ-022 alarm SHALL pulse for exactly one cycle, aligned with the cnt_data load, when thresh != 0 and count >= thresh; thresh=0 disables the alarm.
REQ-023 Handshake: cnt_valid & cnt_ready SHALL consume the report, clearing cnt_valid next cycle unless a new report loads that same cycle.
REQ-024 A new report with cnt_valid=1 and cnt_ready=0 SHALL overwrite cnt_data, keep cnt_valid=1, and set overrun.
REQ-025 A new report in the same cycle as a valid&ready consume SHALL load cleanly with cnt_valid=1 and no overrun.
REQ-026 overrun SHALL clear on ovr_clr=1 unless a set event occurs in the same cycle; set wins.
REQ-027 cnt_data SHALL remain stable while cnt_valid=1 and no new report loads.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE; hit_cnt, win_cnt, cnt_data = 0; cnt_valid, alarm, overrun = 0.
REQ-029 rst asserted mid-window SHALL discard the partial count; after release, counting starts only via REQ-016.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, COUNT=1'b1) and the CNT_W/WIN_W defaults.
REQ-031 The output report register and overrun logic SHALL be one sub-module, seq_hit_report_reg; the FSM and counters stay in the top.

Verification
REQ-032 enable=1, win_len=10, thresh=3, hits on window cycles 2,5,9, cnt_ready=1 -> cnt_data=3, cnt_valid 1 cycle, alarm 1 pulse.
REQ-033 win_len=4, hit held 1, CNT_W=2 -> per-window cnt_data=3 (saturated); back-to-back windows every 4 cycles, no gap.
REQ-034 cnt_ready=0, two windows of win_len=5 -> second report overwrites, overrun=1; ovr_clr pulse -> overrun=0.
REQ-035 enable drops on window cycle 3 of 8 -> IDLE, no cnt_valid, no alarm; re-enable restarts with count 0.
REQ-036 rst asserted mid-window with cnt_valid=1 -> all outputs 0 within the reset; win_len=0 after release -> 1-cycle windows.
REQ-037 Concatenate with the upstream 1011 detector; stream 1011011011 in a 12-cycle window -> cnt_data=3.
